// File: rtl/ws2812_pkg.sv
// Shared types and elaboration helpers for the WS2812 stream driver.
package ws2812_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        LATCH = 2'd3
    } state_t;

    localparam longint unsigned NS_PER_S = 64'd1_000_000_000;

    // Nanoseconds to whole clock cycles, truncating.
    function automatic int unsigned ns_to_cycles(input longint unsigned clk_hz,
                                                 input longint unsigned ns);
        return 32'((clk_hz * ns) / NS_PER_S);
    endfunction

endpackage

// File: rtl/ws2812_stream_driver_if.sv
// Pixel stream handshake between a pixel source and the LED driver.
interface ws2812_stream_driver_if #(
    parameter int unsigned DW = 24
) ();
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          pix_ready;

    modport master (output pix_data, output pix_valid, input  pix_ready);
    modport slave  (input  pix_data, input  pix_valid, output pix_ready);
endinterface

// File: rtl/ws2812_bit_encoder.sv
// Serialises one pixel MSB first into WS2812 high/low bit periods.
module ws2812_bit_encoder #(
    parameter int unsigned DW  = 24,
    parameter int unsigned PER = 31,
    parameter int unsigned H0  = 10,
    parameter int unsigned H1  = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic [DW-1:0] i_data,
    output logic          o_led,
    output logic          o_pixel_done_c
);
    localparam int unsigned CW = $clog2(PER);
    localparam int unsigned IW = (DW > 1) ? $clog2(DW) : 1;

    logic [DW-1:0] r_shift;
    logic [CW-1:0] r_cnt;
    logic [IW-1:0] r_idx;
    logic          r_active;
    logic [CW-1:0] w_high;

    assign w_high         = r_shift[DW-1] ? CW'(H1) : CW'(H0);
    assign o_pixel_done_c = r_active && (r_cnt == CW'(PER - 1)) && (r_idx == IW'(DW - 1));

    // Bit-period counter, shift register and registered pin; a load wins over the end of a pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift  <= '0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_active <= 1'b0;
            o_led    <= 1'b0;
        end else begin
            o_led <= r_active && (r_cnt < w_high);
            if (i_load) begin
                r_shift  <= i_data;
                r_cnt    <= '0;
                r_idx    <= '0;
                r_active <= 1'b1;
            end else if (r_active) begin
                if (r_cnt == CW'(PER - 1)) begin
                    r_cnt <= '0;
                    if (r_idx == IW'(DW - 1)) begin
                        r_active <= 1'b0;
                    end else begin
                        r_idx   <= r_idx + IW'(1);
                        r_shift <= r_shift << 1;
                    end
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ws2812_stream_driver.sv
// WS2812 frame driver: pulls scaled pixels over a stream into a one-deep buffer and sends them.
module ws2812_stream_driver
    import ws2812_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 25_000_000,
    parameter int unsigned LED_CNT     = 8,
    parameter int unsigned CHANNELS    = 3,
    parameter int unsigned BPC         = 8,
    parameter int unsigned T_PERIOD_NS = 1250,
    parameter int unsigned T0H_NS      = 400,
    parameter int unsigned T1H_NS      = 800,
    parameter int unsigned T_RESET_NS  = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [BPC-1:0]       brightness,
    ws2812_stream_driver_if.slave pix,
    output logic                 busy,
    output logic                 done,
    output logic                 underrun,
    output logic                 led_o
);
    localparam int unsigned DW     = CHANNELS * BPC;
    localparam int unsigned PW     = 2 * BPC + 1;
    localparam int unsigned PER    = ns_to_cycles(64'(CLK_HZ), 64'(T_PERIOD_NS));
    localparam int unsigned H0     = ns_to_cycles(64'(CLK_HZ), 64'(T0H_NS));
    localparam int unsigned H1     = ns_to_cycles(64'(CLK_HZ), 64'(T1H_NS));
    localparam int unsigned RST    = ns_to_cycles(64'(CLK_HZ), 64'(T_RESET_NS));
    localparam int unsigned RST_M2 = (RST >= 2) ? RST - 2 : 0;
    localparam int unsigned LCW    = (RST > 0) ? $clog2(RST + 1) : 1;
    localparam int unsigned PCW    = $clog2(LED_CNT + 1);

    if (H0 < 1 || H1 <= H0 || PER <= H1) begin : g_bad_timing
        $error("ws2812_stream_driver: invalid bit timing H0=%0d H1=%0d PER=%0d", H0, H1, PER);
    end
    if (LED_CNT < 1) begin : g_bad_led_cnt
        $error("ws2812_stream_driver: LED_CNT must be at least 1");
    end

    state_t           r_state;
    logic [BPC-1:0]   r_bright;
    logic [DW-1:0]    r_buf;
    logic             r_buf_full;
    logic [PCW-1:0]   r_acc;
    logic [LCW-1:0]   r_lcnt;
    logic [DW-1:0]    w_scaled;
    logic             w_pix_ready;
    logic             w_xfer;
    logic             w_load;
    logic             w_pix_done;

    assign w_pix_ready   = !r_buf_full && (r_state == FETCH || r_state == SEND)
                           && (r_acc < PCW'(LED_CNT));
    assign pix.pix_ready = w_pix_ready;
    assign w_xfer        = pix.pix_valid && w_pix_ready;
    assign w_load        = r_buf_full && ((r_state == FETCH) || (r_state == SEND && w_pix_done));

    // Per-channel brightness scaling: (ch * (brightness + 1)) >> BPC.
    always_comb begin
        w_scaled = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_scaled[c*BPC +: BPC] = BPC'((PW'(pix.pix_data[c*BPC +: BPC])
                                          * (PW'(r_bright) + PW'(1))) >> BPC);
        end
    end

    // Frame control FSM with prefetch buffer, pixel count and latch timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_bright   <= '0;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_acc      <= '0;
            r_lcnt     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (w_xfer) begin
                r_buf      <= w_scaled;
                r_buf_full <= 1'b1;
                r_acc      <= r_acc + PCW'(1);
            end else if (w_load) begin
                r_buf_full <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state    <= FETCH;
                        r_bright   <= brightness;
                        r_acc      <= '0;
                        r_buf_full <= 1'b0;
                        underrun   <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                FETCH: begin
                    if (r_buf_full) r_state <= SEND;
                end
                SEND: begin
                    // With a pixel buffered the encoder reloads seamlessly; otherwise the frame ends.
                    if (w_pix_done && !r_buf_full) begin
                        r_state    <= LATCH;
                        r_lcnt     <= '0;
                        r_buf_full <= 1'b0;
                        done       <= (RST == 1);
                        if (r_acc != PCW'(LED_CNT)) underrun <= 1'b1;
                    end
                end
                LATCH: begin
                    r_lcnt <= r_lcnt + LCW'(1);
                    if (RST >= 2 && r_lcnt == LCW'(RST_M2)) done <= 1'b1;
                    if (r_lcnt == LCW'(RST - 1)) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    ws2812_bit_encoder #(
        .DW  (DW),
        .PER (PER),
        .H0  (H0),
        .H1  (H1)
    ) u_enc (
        .clk            (clk),
        .reset          (reset),
        .i_load         (w_load),
        .i_data         (r_buf),
        .o_led          (led_o),
        .o_pixel_done_c (w_pix_done)
    );

endmodule
